clk_div_monitor: RTL and testbench
==================================

Name: clk_div_monitor

Overview:
- Measuring end for the divided clocks produced by the clock generator.
- Samples one divided-clock signal in the clk_in domain and measures its high time, low time and period in clk_in cycles.
- Compares each measurement against expected values and flags mismatches and stuck signals.
- Used in lab self-check and on-board debug, alongside the generator.

Parameters:
CNT_W, 8, width of the high/low phase counters (period output is CNT_W+1).
TIMEOUT, 255, phase length in clk_in cycles that declares sig_in stuck; must be ≤ 2^CNT_W-1.

Ports:
clk_in  input  1  system clock; all logic on its rising edge.
rst  input  1  asynchronous, active-low reset.
enable  input  1  1 = measure; 0 = return to WAIT_RISE, hold all outputs.
sig_in  input  1  divided clock under test, generated from clk_in.
exp_period  input  CNT_W+1  expected period in clk_in cycles.
exp_high  input  CNT_W  expected high cycles per period.
period_out  output  CNT_W+1  last measured period.
high_out  output  CNT_W  last measured high cycles.
low_out  output  CNT_W  last measured low cycles.
meas_valid  output  1  one-cycle pulse when the *_out registers update.
match  output  1  registered with meas_valid: period and high both equal expected.
err_count  output  8  count of mismatched measurements; saturates at 255.
stuck  output  1  sticky: a phase reached TIMEOUT without an edge.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, s1=s2=0, counters 0, state WAIT_RISE.
- Edge detection:
  - Two-flop sample: s1<=sig_in, s2<=s1.
  - rise = s1 & ~s2; fall = ~s1 & s2.
  - This gives a fixed 1-cycle detection latency, which does not affect measured lengths.
- Phase length: number of clk_in edges at which s1 holds that level.
- FSM states WAIT_RISE, HIGH, LOW:
  - WAIT_RISE: on rise, hcnt<=1 and go to HIGH. The partial period after reset or enable is discarded.
  - HIGH: hcnt increments while s1=1. On fall, lcnt<=1 and go to LOW.
  - LOW: lcnt increments while s1=0. On rise, publish and go to HIGH with hcnt<=1, lcnt<=0.
- Publish (registered, same edge):
  - high_out<=hcnt, low_out<=lcnt, period_out<=hcnt+lcnt computed at CNT_W+1 width.
  - meas_valid<=1 for one cycle.
  - match<=(hcnt+lcnt==exp_period)&&(hcnt==exp_high).
  - err_count increments on mismatch, saturating at 255.
  - stuck clears.
- Throughput: back-to-back periods are measured without gaps. The first meas_valid arrives at the second detected rise.
- Stuck:
  - When the active phase counter equals TIMEOUT, stuck<=1, go to WAIT_RISE, and publish nothing.
  - Counters never wrap.
- enable=0: state forced to WAIT_RISE on the next edge. Outputs, stuck and err_count hold. Counters clear.
- Same-cycle events: rise and timeout cannot coincide (the timeout condition requires no edge in that cycle). A published match uses the exp_* values sampled on the publish edge.
- Reset mid-measurement: immediate clear; measurement restarts from WAIT_RISE.

Decomposition:
- Shared package clk_mon_pkg holds:
  - state enum (WAIT_RISE, HIGH, LOW);
  - default CNT_W and TIMEOUT constants.
- One sub-module, edge_detect: two-flop sampler with rise/fall outputs, async active-low reset. It is reusable by other blocks that observe the generator.

Test Plan:
1. Stimulus: rst=0 held 3 cycles mid-run, with sig_in toggling. Response: all outputs 0 during reset and immediately after release; no meas_valid until two rises have been seen.
2. Stimulus: sig_in toggling every clk_in edge (div-2), exp_period=2, exp_high=1. Response: meas_valid every 2 cycles with period_out=2, high_out=1, low_out=1, match=1, err_count=0.
3. Stimulus: sig_in 13 high / 13 low (div-26), exp_period=26, exp_high=13. Response: period_out=26, high_out=13, low_out=13, match=1.
4. Stimulus: sig_in 1 high / 2 low (div-3, 33% duty), exp_period=3, exp_high=2. Response: period_out=3, high_out=1, low_out=2, match=0, err_count increments by 1 each period and reaches 255 then holds.
5. Stimulus: sig_in held 1 for 300 cycles, TIMEOUT=255. Response: stuck=1 after the 255th high cycle and no meas_valid. Then resume div-4 toggling. Response: first meas_valid at the second rise with period_out=4, stuck back to 0.
6. Stimulus: enable=0 mid-period, then enable=1. Response: outputs hold while enable is low; the partial period is discarded; the next valid measurement is correct.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the divided-clock monitor.
package clk_mon_pkg;
    localparam int CNT_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        WAIT_RISE,
        HIGH,
        LOW
    } state_t;
endpackage

// File: rtl/edge_detect.sv
// Two-flop sampler of a clk_in-derived signal with rise/fall strobes.
module edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);
    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
        end
    end

    assign rise_o = s1_q & ~s2_q;
    assign fall_o = ~s1_q & s2_q;
endmodule

// File: rtl/clk_div_monitor.sv
// Measures high, low and period of a divided clock in clk_in cycles
// and flags mismatches against expected values and stuck phases.
import clk_mon_pkg::*;

module clk_div_monitor #(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             sig_in,
    input  logic [CNT_W:0]   exp_period,
    input  logic [CNT_W-1:0] exp_high,
    output logic [CNT_W:0]   period_out,
    output logic [CNT_W-1:0] high_out,
    output logic [CNT_W-1:0] low_out,
    output logic             meas_valid,
    output logic             match,
    output logic [7:0]       err_count,
    output logic             stuck
);
    localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic rise;
    logic fall;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [CNT_W:0]   per_q, per_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic             valid_q, valid_d;
    logic             match_q, match_d;
    logic [7:0]       err_q, err_d;
    logic             stuck_q, stuck_d;
    logic [CNT_W:0]   sum;
    logic             hit;

    edge_detect u_edge (
        .clk_i  (clk_in),
        .rst_ni (rst),
        .sig_i  (sig_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign sum = {1'b0, hcnt_q} + {1'b0, lcnt_q};
    assign hit = (sum == exp_period) && (hcnt_q == exp_high);

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        lcnt_d  = lcnt_q;
        per_d   = per_q;
        high_d  = high_q;
        low_d   = low_q;
        valid_d = 1'b0;
        match_d = match_q;
        err_d   = err_q;
        stuck_d = stuck_q;
        if (!enable) begin
            state_d = WAIT_RISE;
            hcnt_d  = '0;
            lcnt_d  = '0;
        end else begin
            unique case (state_q)
                WAIT_RISE: begin
                    if (rise) begin
                        hcnt_d  = ONE;
                        lcnt_d  = '0;
                        state_d = HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        lcnt_d  = ONE;
                        state_d = LOW;
                    end else if (hcnt_q == TO) begin
                        stuck_d = 1'b1;
                        hcnt_d  = '0;
                        state_d = WAIT_RISE;
                    end else begin
                        hcnt_d = hcnt_q + ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        // Publish the completed period and start the next one
                        per_d   = sum;
                        high_d  = hcnt_q;
                        low_d   = lcnt_q;
                        valid_d = 1'b1;
                        match_d = hit;
                        stuck_d = 1'b0;
                        if (!hit && err_q != 8'hFF) err_d = err_q + 8'd1;
                        hcnt_d  = ONE;
                        lcnt_d  = '0;
                        state_d = HIGH;
                    end else if (lcnt_q == TO) begin
                        stuck_d = 1'b1;
                        hcnt_d  = '0;
                        lcnt_d  = '0;
                        state_d = WAIT_RISE;
                    end else begin
                        lcnt_d = lcnt_q + ONE;
                    end
                end
                default: state_d = WAIT_RISE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT_RISE;
            hcnt_q  <= '0;
            lcnt_q  <= '0;
            per_q   <= '0;
            high_q  <= '0;
            low_q   <= '0;
            valid_q <= 1'b0;
            match_q <= 1'b0;
            err_q   <= '0;
            stuck_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            lcnt_q  <= lcnt_d;
            per_q   <= per_d;
            high_q  <= high_d;
            low_q   <= low_d;
            valid_q <= valid_d;
            match_q <= match_d;
            err_q   <= err_d;
            stuck_q <= stuck_d;
        end
    end

    assign period_out = per_q;
    assign high_out   = high_q;
    assign low_out    = low_q;
    assign meas_valid = valid_q;
    assign match      = match_q;
    assign err_count  = err_q;
    assign stuck      = stuck_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed self-checking bench for clk_div_monitor.
module tb_clk_div_monitor;
    logic       clk_in = 1'b0;
    logic       rst;
    logic       enable;
    logic       sig_in;
    logic [8:0] exp_period;
    logic [7:0] exp_high;
    logic [8:0] period_out;
    logic [7:0] high_out;
    logic [7:0] low_out;
    logic       meas_valid;
    logic       match;
    logic [7:0] err_count;
    logic       stuck;

    int checks = 0;
    int failures = 0;
    int exp_err = 0;

    always #5 clk_in = ~clk_in;

    clk_div_monitor dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .enable     (enable),
        .sig_in     (sig_in),
        .exp_period (exp_period),
        .exp_high   (exp_high),
        .period_out (period_out),
        .high_out   (high_out),
        .low_out    (low_out),
        .meas_valid (meas_valid),
        .match      (match),
        .err_count  (err_count),
        .stuck      (stuck)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Runs nper periods of hi/lo after two low cycles; checks every publish.
    task automatic wave(input bit clear, input int hi, input int lo,
                        input int nper, input int ep, input int eh,
                        input bit em);
        int nv;
        int len;
        nv = 0;
        len = hi + lo;
        exp_period = 9'(ep);
        exp_high = 8'(eh);
        if (clear) begin
            enable = 1'b0;
            sig_in = 1'b0;
            repeat (3) tick();
            enable = 1'b1;
        end
        for (int c = 0; c < 2 + nper * len; c++) begin
            sig_in = (c >= 2) && (((c - 2) % len) < hi);
            tick();
            if (meas_valid) begin
                nv++;
                if (!em && exp_err < 255) exp_err++;
                checks++;
                if (period_out !== 9'(len)) begin
                    failures++;
                    $display("FAIL period hi=%0d lo=%0d got=%0d want=%0d",
                             hi, lo, period_out, len);
                end
                checks++;
                if (high_out !== 8'(hi) || low_out !== 8'(lo)) begin
                    failures++;
                    $display("FAIL phases got=%0d/%0d want=%0d/%0d",
                             high_out, low_out, hi, lo);
                end
                checks++;
                if (match !== em) begin
                    failures++;
                    $display("FAIL match hi=%0d lo=%0d got=%0b want=%0b",
                             hi, lo, match, em);
                end
                checks++;
                if (err_count !== 8'(exp_err)) begin
                    failures++;
                    $display("FAIL err_count got=%0d want=%0d",
                             err_count, exp_err);
                end
                checks++;
                if (stuck !== 1'b0) begin
                    failures++;
                    $display("FAIL stuck_clear got=%0b want=0", stuck);
                end
            end
        end
        checks++;
        if (nv != nper - 1) begin
            failures++;
            $display("FAIL valid_count hi=%0d lo=%0d got=%0d want=%0d",
                     hi, lo, nv, nper - 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enable = 1'b1;
        sig_in = 1'b0;
        exp_period = 9'd2;
        exp_high = 8'd1;
        repeat (3) tick();
        checks++;
        if ({period_out, high_out, low_out, meas_valid, match,
             err_count, stuck} !== '0) begin
            failures++;
            $display("FAIL reset_init got=%0d/%0d/%0d v=%0b want=0",
                     period_out, high_out, low_out, meas_valid);
        end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sig_in = ~sig_in;
            tick();
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({period_out, high_out, low_out, meas_valid, match,
             err_count, stuck} !== '0) begin
            failures++;
            $display("FAIL reset_async got=%0d/%0d/%0d v=%0b want=0",
                     period_out, high_out, low_out, meas_valid);
        end
        for (int i = 0; i < 3; i++) begin
            sig_in = ~sig_in;
            tick();
            checks++;
            if ({period_out, high_out, low_out, meas_valid, match,
                 err_count, stuck} !== '0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%0d v=%0b want=0",
                         i, period_out, meas_valid);
            end
        end
        sig_in = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            sig_in = (c >= 2) && (c % 2 == 0);
            tick();
            checks++;
            if (meas_valid !== (c == 5)) begin
                failures++;
                $display("FAIL first_valid cyc=%0d got=%0b want=%0b",
                         c, meas_valid, c == 5);
            end
        end
        checks++;
        if (period_out !== 9'd2 || high_out !== 8'd1 || match !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_meas got=%0d/%0d m=%0b want=2/1 m=1",
                     period_out, high_out, match);
        end
    endtask

    task automatic test_div2();
        wave(1'b1, 1, 1, 10, 2, 1, 1'b1);
    endtask

    task automatic test_div26();
        wave(1'b1, 13, 13, 4, 26, 13, 1'b1);
    endtask

    task automatic test_err_saturate();
        wave(1'b1, 1, 2, 11, 3, 2, 1'b0);
        wave(1'b1, 1, 2, 260, 3, 2, 1'b0);
    endtask

    task automatic test_stuck();
        enable = 1'b0;
        sig_in = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        repeat (2) tick();
        sig_in = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            checks++;
            if (meas_valid !== 1'b0) begin
                failures++;
                $display("FAIL stuck_no_valid cyc=%0d got=1 want=0", i);
            end
            if (i == 256) begin
                checks++;
                if (stuck !== 1'b0) begin
                    failures++;
                    $display("FAIL stuck_early got=%0b want=0", stuck);
                end
            end
            if (i == 257) begin
                checks++;
                if (stuck !== 1'b1) begin
                    failures++;
                    $display("FAIL stuck_set got=%0b want=1", stuck);
                end
            end
        end
        checks++;
        if (stuck !== 1'b1) begin
            failures++;
            $display("FAIL stuck_sticky got=%0b want=1", stuck);
        end
        wave(1'b0, 2, 2, 5, 4, 2, 1'b1);
    endtask

    task automatic test_enable();
        wave(1'b1, 4, 4, 3, 8, 4, 1'b1);
        sig_in = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sig_in = (i < 2);
            tick();
            checks++;
            if (period_out !== 9'd8 || high_out !== 8'd4 || low_out !== 8'd4
                || match !== 1'b1 || meas_valid !== 1'b0
                || err_count !== 8'(exp_err)) begin
                failures++;
                $display("FAIL enable_hold cyc=%0d got=%0d/%0d/%0d m=%0b v=%0b e=%0d want=8/4/4 m=1 v=0 e=%0d",
                         i, period_out, high_out, low_out, match,
                         meas_valid, err_count, exp_err);
            end
        end
        enable = 1'b1;
        wave(1'b0, 4, 4, 3, 8, 4, 1'b1);
    endtask

    initial begin
        test_reset();
        test_div2();
        test_div26();
        test_err_saturate();
        test_stuck();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
